// File: rtl/mld_code_pkg.sv
// Shared constants, FSM state type and reference encoder for the (15,11)
// cyclic Hamming code with generator g(x) = 1 + x + x^4.
package mld_code_pkg;

    localparam int N  = 15;
    localparam int K  = 11;
    localparam int NK = N - K;

    // Generator coefficients g4..g0; both end coefficients must be 1.
    localparam logic [NK:0] GEN_POLY = 5'b10011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MSG  = 2'd1,
        PAR  = 2'd2,
        DONE = 2'd3
    } enc_state_e;

    // Systematic codeword; bit N-1 is the first bit on the wire.
    // m[K-1] is the coefficient of x^(K-1).
    function automatic logic [N-1:0] encode15(input logic [K-1:0] m);
        logic [N-1:0] rem;
        rem = {m, {NK{1'b0}}};
        for (int i = N - 1; i >= NK; i--) begin
            if (rem[i]) begin
                rem[i -: NK + 1] = rem[i -: NK + 1] ^ GEN_POLY;
            end
        end
        return {m, rem[NK-1:0]};
    endfunction

endpackage

// File: rtl/cyclic_parity_lfsr.sv
// Division-by-g(x) LFSR that accumulates the parity of a serial message.
// With fb_en low the register degenerates into a plain shift toward the
// top bit, which is how the parity is streamed out afterwards.
module cyclic_parity_lfsr
    import mld_code_pkg::*;
#(
    parameter logic [NK:0] GEN_POLY_P = GEN_POLY
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          shift,
    input  logic          din,
    input  logic          fb_en,
    output logic [NK-1:0] parity
);

    logic [NK-1:0] r_q;
    logic [NK-1:0] r_d;
    logic [NK-1:0] base;
    logic          fb;

    // Next register value; clr and shift together shift into a cleared register,
    // so the first message bit can be absorbed on the same edge it is captured.
    always_comb begin
        base = clr ? '0 : r_q;
        fb   = fb_en ? (din ^ base[NK-1]) : 1'b0;
        r_d  = base;
        if (shift) begin
            r_d[0] = fb;
            for (int j = 1; j < NK; j++) begin
                r_d[j] = base[j-1] ^ (GEN_POLY_P[j] & fb);
            end
        end
    end

    // Parity register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign parity = r_q;

endmodule

// File: rtl/cyclic_serial_encoder.sv
// Serial systematic encoder for the (15,11) cyclic Hamming code.
// Accepts an 11-bit message on start and emits 15 bits, message first.
//
// state | meaning
// IDLE  | waiting for start, outputs low
// MSG   | bit_out carries message bit cnt (0..10)
// PAR   | bit_out carries parity bit cnt (11..14)
// DONE  | one-cycle done pulse, then back to IDLE
//
// Outputs are registered and loaded on the edge that moves into the state
// they describe, so the first bit appears in the cycle right after start.
module cyclic_serial_encoder
    import mld_code_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [0:K-1] message,
    output logic         busy,
    output logic         load,
    output logic         bit_out,
    output logic         done
);

    localparam logic [3:0] LAST_MSG = 4'(K - 1);
    localparam logic [3:0] LAST_BIT = 4'(N - 1);

    enc_state_e   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [0:K-1] sr_q, sr_d;
    logic         bit_q, bit_d;
    logic         load_q, load_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic          lfsr_clr;
    logic          lfsr_shift;
    logic          lfsr_din;
    logic          lfsr_fb_en;
    logic [NK-1:0] parity;
    logic          unused_parity_low;

    cyclic_parity_lfsr #(
        .GEN_POLY_P(GEN_POLY)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .clr   (lfsr_clr),
        .shift (lfsr_shift),
        .din   (lfsr_din),
        .fb_en (lfsr_fb_en),
        .parity(parity)
    );

    // Only the top parity bit is ever read; the rest reach it by shifting.
    assign unused_parity_low = ^parity[NK-2:0];

    // Next-state, counter, shift register and next output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        bit_d      = 1'b0;
        load_d     = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        lfsr_clr   = 1'b0;
        lfsr_shift = 1'b0;
        lfsr_din   = 1'b0;
        lfsr_fb_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = MSG;
                    cnt_d      = 4'd0;
                    sr_d       = {message[1:K-1], 1'b0};
                    bit_d      = message[0];
                    load_d     = 1'b1;
                    busy_d     = 1'b1;
                    lfsr_clr   = 1'b1;
                    lfsr_shift = 1'b1;
                    lfsr_din   = message[0];
                    lfsr_fb_en = 1'b1;
                end
            end
            MSG: begin
                load_d     = 1'b1;
                busy_d     = 1'b1;
                lfsr_shift = 1'b1;
                cnt_d      = cnt_q + 4'd1;
                if (cnt_q == LAST_MSG) begin
                    // Parity is complete; start streaming it out.
                    state_d = PAR;
                    bit_d   = parity[NK-1];
                end else begin
                    bit_d      = sr_q[0];
                    sr_d       = {sr_q[1:K-1], 1'b0};
                    lfsr_din   = sr_q[0];
                    lfsr_fb_en = 1'b1;
                end
            end
            PAR: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    load_d     = 1'b1;
                    busy_d     = 1'b1;
                    lfsr_shift = 1'b1;
                    cnt_d      = cnt_q + 4'd1;
                    bit_d      = parity[NK-1];
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sr_q    <= '0;
            bit_q   <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bit_out = bit_q;
    assign load    = load_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_cyclic_serial_encoder.sv
// Bench for cyclic_serial_encoder: a frame-timeline model predicts every
// output on every cycle; directed frames also pin literal bit streams.
module tb_cyclic_serial_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [0:10] message = '0;
    logic        busy, load, bit_out, done;

    int n_checks = 0;
    int n_pass   = 0;

    cyclic_serial_encoder dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .message(message),
        .busy   (busy),
        .load   (load),
        .bit_out(bit_out),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Codeword from polynomial division: c = m*x^4 + (m*x^4 mod g), g = x^4+x+1.
    function automatic logic [14:0] model_cw(input logic [10:0] m);
        int val;
        val = int'(m) << 4;
        for (int d = 14; d >= 4; d--) begin
            if (((val >> d) & 1) == 1) val = val ^ (19 << (d - 4));
        end
        return 15'((int'(m) << 4) | (val & 15));
    endfunction

    // Model: phase -1 idle, 0..14 bit index on the wire, 15 the done cycle.
    int          phase = -1;
    logic [14:0] model_word = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            phase = -1;
        end else if (phase == -1) begin
            if (start) begin
                assert (!$isunknown(message));
                model_cw_capture();
                phase = 0;
            end
        end else if (phase == 15) begin
            phase = -1;
        end else begin
            phase = phase + 1;
        end
    end

    task automatic model_cw_capture();
        logic [10:0] m;
        m = message;
        model_word = model_cw(m);
    endtask

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [3:0] exp_v;
        logic       e_load;
        if (!reset) begin
            e_load = (phase >= 0) && (phase <= 14);
            exp_v  = {e_load, e_load, e_load ? model_word[14 - phase] : 1'b0, phase == 15};
            check({busy, load, bit_out, done} == exp_v, "cycle_outputs", 32'({busy, load, bit_out, done}), 32'(exp_v));
        end
    end

    // One frame: returns the 15 bits seen while load was high and the cycle of done.
    task automatic run_frame(input logic [10:0] m, input logic [14:0] exp, input string name, input bit noise);
        logic [14:0] got;
        int          nbits;
        int          done_at;
        int          k;
        got = '0; nbits = 0; done_at = 0;
        @(negedge clk);
        message = m;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        message = 11'($urandom);
        k = 1;
        while (k <= 40 && done_at == 0) begin
            if (load) begin
                got = {got[13:0], bit_out};
                nbits++;
            end
            if (done) done_at = k;
            start = noise && (k == 3 || k == 9);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check(got == exp, {name, "_stream"}, 32'(got), 32'(exp));
        check(nbits == 15, {name, "_load_len"}, 32'(nbits), 32'd15);
        check(done_at == 16, {name, "_done_cycle"}, 32'(done_at), 32'd16);
    endtask

    initial begin
        int          ndone;
        logic [10:0] rm;

        // Pin the model against hand-derived codewords.
        check(model_cw(11'b0) == 15'b0, "model_zero", 32'(model_cw(11'b0)), 32'h0);
        check(model_cw(11'b00000000001) == 15'b000000000010011, "model_one", 32'(model_cw(11'b1)), 32'h13);
        check(model_cw(11'b10000000000) == 15'b100000000001001, "model_x10", 32'(model_cw(11'b10000000000)), 32'h4009);
        check(model_cw(11'b10110011101) == 15'b101100111011001, "model_mix", 32'(model_cw(11'b10110011101)), 32'h59D9);

        repeat (3) @(negedge clk);
        check({busy, load, bit_out, done} == 4'b0, "reset_state", 32'({busy, load, bit_out, done}), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(11'b0, 15'b000000000000000, "zero", 1'b0);
        check(busy == 1'b0, "zero_busy_after", 32'(busy), 32'h0);
        run_frame(11'b00000000001, 15'b000000000010011, "m_one", 1'b0);
        run_frame(11'b10000000000, 15'b100000000001001, "m_x10", 1'b0);
        run_frame(11'b10110011101, 15'b101100111011001, "m_mix", 1'b0);
        run_frame(11'b10110011101, 15'b101100111011001, "m_mix_noise", 1'b1);

        // start held high for 40 cycles: two completed frames.
        @(negedge clk);
        message = 11'($urandom);
        start   = 1'b1;
        ndone   = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
            message = 11'($urandom);
        end
        start = 1'b0;
        check(ndone == 2, "held_start_frames", 32'(ndone), 32'd2);
        repeat (25) @(negedge clk);

        // Asynchronous reset in the parity phase.
        @(negedge clk);
        message = 11'b11111111111;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check({busy, load, bit_out, done} == 4'b0, "async_reset_outputs", 32'({busy, load, bit_out, done}), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check(ndone == 0, "no_done_after_reset", 32'(ndone), 32'd0);
        run_frame(11'b01101001011, model_cw(11'b01101001011), "post_reset", 1'b0);

        // Randomized frames with random gaps and ignored start pulses.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rm = 11'($urandom);
            run_frame(rm, model_cw(rm), "rand_frame", 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cyclic_serial_encoder.md
Name: cyclic_serial_encoder

Overview:
- Systematic serial encoder for the (15,11) cyclic Hamming code, generator g(x)=1+x+x^4.
- Sits directly upstream of Multi_Step_MLD_decoder and drives its `load` and `received_bit_stream` inputs (through the channel / error-injection model in system benches).
- Accepts an 11-bit message in parallel on a start strobe and emits the 15-bit codeword serially, one bit per clock, message bits first, then parity.
- Holds `load` high for exactly the 15 bit cycles.

Parameters:
- N, 15, codeword length.
- K, 11, message length.
- GEN_POLY, 5'b10011, generator coefficients g4..g0 (g4 and g0 must be 1).

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to encode `message`; sampled only in IDLE.
- message  input  [0:K-1]  message bits; message[i] is the coefficient of x^(K-1-i) in m(x).
- busy  output  1  high from the cycle after an accepted start until `done`.
- load  output  1  high while `bit_out` carries a valid codeword bit (15 cycles).
- bit_out  output  1  serial codeword bit, registered.
- done  output  1  one-cycle pulse in the cycle after the last codeword bit.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - busy=0, load=0, bit_out=0, done=0.
  - Parity register cleared, counters cleared, FSM forced to IDLE.
  - A partially sent frame is abandoned; no done pulse.
- Codeword: c(x) = x^(N-K)·m(x) + (x^(N-K)·m(x) mod g(x)).
  - Bit sent in output cycle t (t=0..14) is the coefficient of x^(14-t).
  - Therefore t=0..10 carry message[0..10], and t=11..14 carry parity p3..p0.
- FSM states: IDLE, MSG, PAR, DONE.
  - IDLE: on start=1 at edge e0, capture message into a shift register, clear parity, go to MSG. Message may change after e0.
  - MSG: 11 cycles. From edge e1, bit_out = current message MSB and load=1.
    - LFSR update: fb = msg_bit ^ r[3]; r0 <= fb; rj <= r(j-1) ^ (g_j & fb) for j=1..3.
    - After 11 bits, go to PAR.
  - PAR: 4 cycles. bit_out = r[3] and load=1; LFSR shifts with fb forced to 0, i.e. a plain shift toward r[3]. After 4 bits, go to DONE.
  - DONE: load=0, bit_out=0, done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- Latency: first bit valid in the cycle after the start edge; last bit in cycle 15; done in cycle 16. Next start is accepted in cycle 17 at the earliest.
- load is never high while done=1.
- bit_out=0 whenever load=0.
- Handshake: start is ignored while busy=1 or in DONE; no queuing.
- start held high continuously re-triggers only when back in IDLE (one frame per IDLE visit).
- bit counter is 4 bits, range 0..14, with no wrap beyond 14. The PAR phase length is N-K, derived from the parameters.
- X on message at start is not allowed (verification asserts against it).

Decomposition:
- Package mld_code_pkg holds: N, K, N-K, GEN_POLY, the FSM state enum shared with decoder-side benches, and a reference function `encode15(m)` used by scoreboards.
- One sub-module, cyclic_parity_lfsr:
  - Inputs: clk, reset, clr, shift, din, fb_en.
  - Output: parity[N-K-1:0].
  - Parameterised by GEN_POLY.
- The FSM, counter and message shift register stay in cyclic_serial_encoder.

Test Plan:
- All-zero message, start pulse → load high for 15 cycles, bit stream 000000000000000, done pulse in cycle 16, busy low after.
- message=11'b00000000001 (m(x)=1) → stream 000000000010011 (parity 0011).
- message=11'b10000000000 (m(x)=x^10) → stream 100000000001001 (parity 1001).
- Loopback: encoder into Multi_Step_MLD_decoder.
  - Encode 11'b10110011101 with no error → decoded_vector equals the transmitted codeword and error_value is zero.
  - Repeat with one bit flipped at t=6 → decoder corrects back to the transmitted codeword.
- start asserted at cycles 3 and 9 of a frame → ignored, and the frame output is unchanged. start held high for 40 cycles → exactly two frames, each separated by DONE and IDLE cycles.
- reset asserted asynchronously mid-PAR → load, bit_out, busy and done drop to 0 immediately with no done pulse. A following start produces a correct full frame.
